// File: rtl/vga_scene_sequencer_if.sv
// Signal bundle between the VGA timing/colour path and the scene sequencer.
interface vga_scene_sequencer_if #(
   parameter int SCENE_W = 2
);
   logic               vga_v_sync;
   logic               btn;
   logic [SCENE_W-1:0] scene;
   logic [3:0]         fade;
   logic               scene_change;
   logic [15:0]        frame_cnt;
   logic               skip_ack;

   modport master (output vga_v_sync, btn,
                   input  scene, fade, scene_change, frame_cnt, skip_ack);
   modport slave  (input  vga_v_sync, btn,
                   output scene, fade, scene_change, frame_cnt, skip_ack);
endinterface

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous demo scene sequencer: fades each scene in, holds it, fades it
// out and advances; a debounced button press skips ahead to the fade-out.
module vga_scene_sequencer #(
   parameter int NUM_SCENES       = 4,
   parameter int SCENE_W          = 2,
   parameter int HOLD_FRAMES      = 300,
   parameter int FADE_STEP_FRAMES = 2,
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_scene_sequencer_if.slave bus
);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);
   localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);
   localparam logic               VS_IDLE    = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT, SWITCH} state_t;

   logic        vsync_q, primed, tick;
   logic [15:0] frame_cnt;

   // primed masks the first cycle after reset so a sync level held across release is not an edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q   <= VS_IDLE;
         primed    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         vsync_q <= bus.vga_v_sync;
         primed  <= 1'b1;
         if (tick) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign tick = primed & (vsync_q == VS_IDLE) & (bus.vga_v_sync != VS_IDLE);

   logic            btn_s1, btn_s2, btn_state, deb_done, press;
   logic [DB_W-1:0] deb_cnt;

   assign deb_done = (btn_s2 != btn_state) && (deb_cnt == DB_LAST);
   assign press    = deb_done & btn_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_s1    <= 1'b0;
         btn_s2    <= 1'b0;
         btn_state <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         btn_s1 <= bus.btn;
         btn_s2 <= btn_s1;
         if (btn_s2 == btn_state) begin
            deb_cnt <= '0;
         end else if (deb_done) begin
            deb_cnt   <= '0;
            btn_state <= btn_s2;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   state_t             state, state_n;
   logic [3:0]         fade, fade_n;
   logic [STEP_W-1:0]  step_cnt, step_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic [SCENE_W-1:0] scene, scene_n;
   logic               scene_change, scene_change_n, skip_ack, skip_ack_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= FADE_IN;
         fade         <= '0;
         step_cnt     <= '0;
         hold_cnt     <= '0;
         scene        <= '0;
         scene_change <= 1'b0;
         skip_ack     <= 1'b0;
      end else begin
         state        <= state_n;
         fade         <= fade_n;
         step_cnt     <= step_n;
         hold_cnt     <= hold_n;
         scene        <= scene_n;
         scene_change <= scene_change_n;
         skip_ack     <= skip_ack_n;
      end
   end

   always_comb begin
      state_n        = state;
      fade_n         = fade;
      step_n         = step_cnt;
      hold_n         = hold_cnt;
      scene_n        = scene;
      scene_change_n = 1'b0;
      skip_ack_n     = 1'b0;
      case (state)
         FADE_IN: begin
            if (press) begin
               state_n    = FADE_OUT;
               step_n     = '0;
               skip_ack_n = 1'b1;
            end else if (tick) begin
               if (step_cnt == STEP_LAST) begin
                  step_n = '0;
                  if (fade != 4'd15) fade_n = fade + 4'd1;
                  if (fade >= 4'd14) begin
                     state_n = HOLD;
                     hold_n  = '0;
                  end
               end else begin
                  step_n = step_cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            fade_n = 4'd15;
            // a press on the same cycle as a tick takes priority; that tick is not counted
            if (press) begin
               state_n    = FADE_OUT;
               step_n     = '0;
               skip_ack_n = 1'b1;
            end else if (tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_n = FADE_OUT;
                  step_n  = '0;
               end else begin
                  hold_n = hold_cnt + 1'b1;
               end
            end
         end
         FADE_OUT: begin
            if (tick) begin
               if (step_cnt == STEP_LAST) begin
                  step_n = '0;
                  if (fade != 4'd0) fade_n = fade - 4'd1;
                  if (fade <= 4'd1) state_n = SWITCH;
               end else begin
                  step_n = step_cnt + 1'b1;
               end
            end
         end
         default: begin
            scene_n        = (scene == SCENE_LAST) ? '0 : scene + 1'b1;
            scene_change_n = 1'b1;
            state_n        = FADE_IN;
            step_n         = '0;
         end
      endcase
   end

   assign bus.scene        = scene;
   assign bus.fade         = fade;
   assign bus.scene_change = scene_change;
   assign bus.frame_cnt    = frame_cnt;
   assign bus.skip_ack     = skip_ack;
endmodule
